// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Encoding of the LED pattern code shared by the key-driven mode selector
// and the downstream LED pattern controller, so both sides agree on one set
// of values.
//   led_mode_t  : 4-bit pattern code; only bits [1:0] are ever non-zero
//   MODE_*      : the four pattern codes
//   next_mode() : short-press successor, OFF->FLASH->RUN->BREATH->OFF
// ---------------------------------------------------------------------------
package led_pkg;

    typedef logic [3:0] led_mode_t;

    localparam led_mode_t MODE_OFF    = 4'd0;
    localparam led_mode_t MODE_FLASH  = 4'd1;
    localparam led_mode_t MODE_RUN    = 4'd2;
    localparam led_mode_t MODE_BREATH = 4'd3;

    // Wraps BREATH back to OFF by incrementing only the low two bits, which
    // also keeps the upper two bits of the code at zero.
    function automatic led_mode_t next_mode(input led_mode_t mode);
        return {2'b00, mode[1:0] + 2'b01};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser followed by a stability counter for one active-low
// push key. The debounced level flips once DEB_CYCLES consecutive
// synchronised samples disagree with it; any agreeing sample restarts the
// count, so shorter bounces are discarded. A one-cycle press or release
// pulse accompanies each flip.
//   sys_clk   in  : clock
//   rst_n     in  : asynchronous active-low reset
//   key_i     in  : raw key, asynchronous, 0 = pressed
//   press_o   out : one-cycle pulse when the debounced level goes 1 -> 0
//   release_o out : one-cycle pulse when the debounced level goes 0 -> 1
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEB_CYCLES = 1
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // The sample that completes the run of disagreeing samples flips the
    // level in the same cycle, so the flip lands DEB_CYCLES samples after
    // the synchroniser output changed.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        level_d   = level_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = sync_q[1];
            press_d   = ~sync_q[1];
            release_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: synchroniser and level reset to 1 (released), so a key
            // held through reset release is seen as a fresh, debounced press.
            sync_q    <= 2'b11;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            sync_q    <= {sync_q[0], key_i};
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/led_mode_select.sv
// ---------------------------------------------------------------------------
// led_mode_select
// Key-driven selector for the LED pattern code. key_next short presses step
// the mode OFF->FLASH->RUN->BREATH->OFF; holding key_next for LONG_CYCLES
// forces OFF while still held; pressing key_off forces OFF. The code is
// registered and changes only on decoded key events.
//   sys_clk  in     : clock
//   rst_n    in     : asynchronous active-low reset
//   key_next in     : raw "next mode" key, 0 = pressed
//   key_off  in     : raw "all off" key, 0 = pressed
//   cntl     out[4] : pattern code (bits [3:2] always 0)
//   mode_chg out    : one-cycle pulse in the first cycle of a new cntl value
// ---------------------------------------------------------------------------
module led_mode_select
    import led_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_next,
    input  logic       key_off,
    output logic [3:0] cntl,
    output logic       mode_chg
);

    localparam int DEB_RAW     = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int DEB_CYCLES  = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int LONG_RAW    = CLK_FREQ / 1000 * LONG_MS;
    localparam int LONG_CYCLES = (LONG_RAW < 2) ? 2 : LONG_RAW;
    localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    // The press pulse cycle counts as the first hold cycle and the register
    // runs one behind the decision edge, so LONG_CYCLES is reached when the
    // registered count shows LONG_CYCLES-2.
    localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONGWAIT
    } kn_state_e;

    logic next_press, next_release;
    logic off_press, off_release_unused;

    kn_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    led_mode_t         mode_q, mode_d;
    logic              chg_q, chg_d;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .key_i     (key_next),
        .press_o   (next_press),
        .release_o (next_release)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_off (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .key_i     (key_off),
        .press_o   (off_press),
        .release_o (off_release_unused)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (next_press) begin
                    state_d = ST_HELD;
                    hold_d  = '0;
                end
            end
            ST_HELD: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // A release arriving in the same cycle the threshold is
                // reached still counts as short: the key was let go first.
                if (next_release) begin
                    mode_d  = next_mode(mode_q);
                    state_d = ST_IDLE;
                end else if (hold_q >= HOLD_HIT) begin
                    mode_d  = MODE_OFF;
                    state_d = ST_LONGWAIT;
                end
            end
            ST_LONGWAIT: begin
                if (next_release) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // key_off overrides whatever the key_next FSM decided this cycle.
        if (off_press) begin
            mode_d = MODE_OFF;
        end
        chg_d = (mode_d != mode_q);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            mode_q  <= MODE_OFF;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            chg_q   <= chg_d;
        end
    end

    assign cntl     = mode_q;
    assign mode_chg = chg_q;

endmodule

// File: tb/tb_led_mode_select.sv
// ---------------------------------------------------------------------------
// tb_led_mode_select
// Self-checking bench for led_mode_select with DEB_CYCLES=5, LONG_CYCLES=50.
// The reference model works on key event timestamps: a debounced level
// flips when the last DEB synchronised raw samples all differ from it, a
// short press advances the mode one cycle after the release flip, a long
// press forces OFF LONG cycles after the press flip, key_off forces OFF one
// cycle after its press flip.
// ---------------------------------------------------------------------------
module tb_led_mode_select;

    localparam int CLK_FREQ    = 1000;
    localparam int DEBOUNCE_MS = 5;
    localparam int LONG_MS     = 50;
    localparam int DEB         = 5;
    localparam int LONG        = 50;

    logic       sys_clk  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       key_next = 1'b1;
    logic       key_off  = 1'b1;
    logic [3:0] cntl;
    logic       mode_chg;

    always #5 sys_clk = ~sys_clk;

    led_mode_select #(
        .CLK_FREQ    (CLK_FREQ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .key_next (key_next),
        .key_off  (key_off),
        .cntl     (cntl),
        .mode_chg (mode_chg)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int n;              // edges since reset release
    int m_mode;         // expected cntl
    bit m_chg;          // expected mode_chg
    bit armed;          // key_next held, long press not yet fired
    int p_time;         // edge at which the key_next press was debounced
    bit lvl_next, lvl_off;
    bit hist_next[$];   // [0] = raw of previous edge, [k] = k edges earlier
    bit hist_off[$];
    bit nxt_press_prev, nxt_rel_prev, off_press_prev;
    int dut_pulses, model_pulses;

    function automatic void model_reset();
        n = 0; m_mode = 0; m_chg = 0; armed = 0; p_time = 0;
        lvl_next = 1; lvl_off = 1;
        nxt_press_prev = 0; nxt_rel_prev = 0; off_press_prev = 0;
        hist_next.delete(); hist_off.delete();
        for (int i = 0; i <= DEB; i++) begin
            hist_next.push_back(1'b1);
            hist_off.push_back(1'b1);
        end
    endfunction

    function automatic bit flips(input int which, input bit lvl);
        for (int i = 1; i <= DEB; i++) begin
            if (which == 0 && hist_next[i] == lvl) return 1'b0;
            if (which == 1 && hist_off[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step(input bit kn, input bit ko);
        int new_mode;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n++;
        new_mode = m_mode;
        if (nxt_rel_prev && armed) begin
            armed = 0;
            if ((n - 1) - p_time < LONG) new_mode = (m_mode + 1) % 4;
        end else if (armed && n == p_time + LONG) begin
            armed = 0;
            new_mode = 0;
        end
        if (nxt_press_prev) begin
            armed = 1;
            p_time = n - 1;
        end
        if (off_press_prev) new_mode = 0;
        m_chg = (new_mode != m_mode);
        m_mode = new_mode;

        nxt_press_prev = 0; nxt_rel_prev = 0; off_press_prev = 0;
        if (flips(0, lvl_next)) begin
            lvl_next = ~lvl_next;
            nxt_press_prev = (lvl_next == 1'b0);
            nxt_rel_prev   = (lvl_next == 1'b1);
        end
        if (flips(1, lvl_off)) begin
            lvl_off = ~lvl_off;
            off_press_prev = (lvl_off == 1'b0);
        end
        hist_next.push_front(kn); void'(hist_next.pop_back());
        hist_off.push_front(ko);  void'(hist_off.pop_back());
    endfunction

    // One clock: model advances on the rising edge, outputs settle by the
    // falling edge where the bench samples and drives.
    task automatic tick();
        @(posedge sys_clk);
        model_step(key_next, key_off);
        @(negedge sys_clk);
        if (mode_chg === 1'b1) dut_pulses++;
        if (m_chg) model_pulses++;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic short_press();
        key_next = 1'b0;
        idle(20);
        key_next = 1'b1;
        idle(12);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        short_press();
        vectors++;
        if (cntl !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_pre cntl=%0d expected=1", cntl);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (cntl !== 4'd0 || mode_chg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async cntl=%0d mode_chg=%0b expected 0/0", cntl, mode_chg);
        end
        idle(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (cntl !== 4'd0 || mode_chg !== 1'b0 || m_mode != 0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d cntl=%0d mode_chg=%0b expected 0/0", i, cntl, mode_chg);
            end
        end
    endtask

    task automatic test_short_press();
        int exp_seq[4] = '{1, 2, 3, 0};
        int prev = 0;
        int p0;
        for (int s = 0; s < 4; s++) begin
            p0 = dut_pulses;
            key_next = 1'b0;
            idle(20);
            key_next = 1'b1;
            idle(7);
            vectors++;
            if (cntl !== 4'(prev)) begin
                miscompares++;
                $display("FAIL short_early step=%0d cntl=%0d expected=%0d", s, cntl, prev);
            end
            tick();
            vectors++;
            if (cntl !== 4'(exp_seq[s]) || mode_chg !== 1'b1 || m_mode != exp_seq[s]) begin
                miscompares++;
                $display("FAIL short_step step=%0d cntl=%0d mode_chg=%0b expected=%0d/1 model=%0d",
                         s, cntl, mode_chg, exp_seq[s], m_mode);
            end
            idle(5);
            vectors++;
            if (dut_pulses - p0 != 1) begin
                miscompares++;
                $display("FAIL short_pulses step=%0d pulses=%0d expected=1", s, dut_pulses - p0);
            end
            prev = exp_seq[s];
        end
    endtask

    task automatic test_bounce();
        int p0 = dut_pulses;
        for (int r = 0; r < 10; r++) begin
            key_next = 1'b0;
            idle(3);
            key_next = 1'b1;
            idle(2);
        end
        idle(20);
        vectors++;
        if (cntl !== 4'd0 || dut_pulses != p0 || m_mode != 0) begin
            miscompares++;
            $display("FAIL bounce cntl=%0d pulses=%0d expected cntl=0 pulses=0", cntl, dut_pulses - p0);
        end
    endtask

    task automatic test_long_press();
        int p0;
        short_press();
        short_press();
        vectors++;
        if (cntl !== 4'd2) begin
            miscompares++;
            $display("FAIL long_setup cntl=%0d expected=2", cntl);
        end
        key_next = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k == 56) begin
                vectors++;
                if (cntl !== 4'd2) begin
                    miscompares++;
                    $display("FAIL long_early cntl=%0d expected=2", cntl);
                end
            end
            if (k == 57) begin
                vectors++;
                if (cntl !== 4'd0 || mode_chg !== 1'b1 || m_mode != 0) begin
                    miscompares++;
                    $display("FAIL long_off cntl=%0d mode_chg=%0b expected 0/1", cntl, mode_chg);
                end
            end
        end
        p0 = dut_pulses;
        key_next = 1'b1;
        idle(30);
        vectors++;
        if (cntl !== 4'd0 || dut_pulses != p0) begin
            miscompares++;
            $display("FAIL long_release cntl=%0d pulses=%0d expected 0/0", cntl, dut_pulses - p0);
        end
    endtask

    task automatic test_off_key();
        int p0;
        short_press();
        short_press();
        short_press();
        vectors++;
        if (cntl !== 4'd3) begin
            miscompares++;
            $display("FAIL off_setup cntl=%0d expected=3", cntl);
        end
        p0 = dut_pulses;
        key_off = 1'b0;
        idle(7);
        vectors++;
        if (cntl !== 4'd3) begin
            miscompares++;
            $display("FAIL off_early cntl=%0d expected=3", cntl);
        end
        tick();
        vectors++;
        if (cntl !== 4'd0 || mode_chg !== 1'b1) begin
            miscompares++;
            $display("FAIL off_press cntl=%0d mode_chg=%0b expected 0/1", cntl, mode_chg);
        end
        idle(10);
        key_off = 1'b1;
        idle(20);
        vectors++;
        if (cntl !== 4'd0 || dut_pulses - p0 != 1) begin
            miscompares++;
            $display("FAIL off_hold cntl=%0d pulses=%0d expected 0/1", cntl, dut_pulses - p0);
        end
        // Release of key_next and press of key_off debounce in the same cycle.
        p0 = dut_pulses;
        key_next = 1'b0;
        idle(20);
        key_next = 1'b1;
        key_off  = 1'b0;
        idle(20);
        vectors++;
        if (cntl !== 4'd0 || dut_pulses != p0 || m_mode != 0) begin
            miscompares++;
            $display("FAIL off_simul cntl=%0d pulses=%0d expected 0/0", cntl, dut_pulses - p0);
        end
        key_off = 1'b1;
        idle(15);
        short_press();
        vectors++;
        if (cntl !== 4'd1) begin
            miscompares++;
            $display("FAIL off_fsm_idle cntl=%0d expected=1", cntl);
        end
    endtask

    task automatic test_reset_mid_press();
        bit found = 0;
        key_next = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (armed && (n - p_time - 1) == 30) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midpress_reach hold=30 not reached within 200 cycles");
        end
        vectors++;
        if (cntl !== 4'd1) begin
            miscompares++;
            $display("FAIL midpress_pre cntl=%0d expected=1", cntl);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (cntl !== 4'd0 || mode_chg !== 1'b0) begin
            miscompares++;
            $display("FAIL midpress_reset cntl=%0d mode_chg=%0b expected 0/0", cntl, mode_chg);
        end
        idle(3);
        rst_n = 1'b1;
        idle(20);
        key_next = 1'b1;
        idle(12);
        vectors++;
        if (cntl !== 4'd1 || m_mode != 1) begin
            miscompares++;
            $display("FAIL midpress_fresh cntl=%0d expected=1 model=%0d", cntl, m_mode);
        end
    endtask

    function automatic int pick_len(input int sel);
        case (sel)
            0:       return int'($urandom_range(4, 1));
            1:       return int'($urandom_range(30, 6));
            default: return int'($urandom_range(90, 40));
        endcase
    endfunction

    task automatic test_random();
        int len_next = 10;
        int len_off  = 150;
        for (int c = 0; c < 3000; c++) begin
            if (c % 997 == 500) begin
                #2 rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            if (--len_next <= 0) begin
                key_next = ~key_next;
                len_next = pick_len(int'($urandom_range(2, 0)));
            end
            if (--len_off <= 0) begin
                key_off = ~key_off;
                len_off = key_off ? int'($urandom_range(300, 60)) : pick_len(int'($urandom_range(2, 0)));
            end
            tick();
            vectors++;
            if (cntl !== 4'(m_mode) || mode_chg !== m_chg) begin
                miscompares++;
                $display("FAIL random cyc=%0d cntl=%0d mode_chg=%0b expected=%0d/%0b",
                         c, cntl, mode_chg, m_mode, m_chg);
            end
        end
        key_next = 1'b1;
        key_off  = 1'b1;
        idle(100);
        vectors++;
        if (cntl !== 4'(m_mode)) begin
            miscompares++;
            $display("FAIL random_tail cntl=%0d expected=%0d", cntl, m_mode);
        end
    endtask

    initial begin
        model_reset();
        dut_pulses = 0;
        model_pulses = 0;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        test_reset();
        test_short_press();
        test_bounce();
        test_long_press();
        test_off_key();
        test_reset_mid_press();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_mode_select.md
# led_mode_select

Key-driven mode selector sitting directly upstream of the LED pattern controller. It debounces two active-low push keys, decodes short and long presses, and holds the 4-bit pattern code (`cntl`) that selects default/off, flash, run or breath. The output is registered, glitch-free and changes only on decoded key events, so the downstream controller can use it directly.

## Interface
**Parameters**
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `DEBOUNCE_MS`, 20: key stability window. Derived `DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS`, minimum 1.
- `LONG_MS`, 1000: long-press threshold. Derived `LONG_CYCLES = CLK_FREQ/1000*LONG_MS`, minimum 2.

**Ports**
- `sys_clk` in, 1: system clock; the block's only clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `key_next` in, 1: raw "next mode" key, asynchronous, 0 = pressed.
- `key_off` in, 1: raw "all off" key, asynchronous, 0 = pressed.
- `cntl` out, 4: pattern code for the LED controller. `cntl[3:2]` is always 0.
- `mode_chg` out, 1: one-cycle pulse in the first cycle `cntl` holds a new, different value.

## Operation
- **Mode codes**
  - OFF = 0.
  - FLASH = 1.
  - RUN = 2.
  - BREATH = 3.
- **Short press of `key_next`** (released before `LONG_CYCLES`): advances the mode OFF→FLASH→RUN→BREATH→OFF, wrapping at 3.
- **Long press of `key_next`**: forces OFF as soon as the hold time reaches `LONG_CYCLES`, while the key is still held. The later release has no effect.
- **Press of `key_off`**: forces OFF on the press edge. Holding or releasing it has no further effect.
- **Key-next FSM states**
  - IDLE: on a debounced press, go to HELD and clear the hold counter.
  - HELD: the hold counter increments and saturates. A debounced release with hold < `LONG_CYCLES` advances the mode and returns to IDLE. When hold reaches `LONG_CYCLES`, mode becomes OFF and the FSM goes to LONGWAIT.
  - LONGWAIT: a debounced release returns to IDLE with no mode change.
- **Simultaneous events**: a `key_off` press in the same cycle as a `key_next` advance or long-press gives OFF. The key-next FSM still takes its own transition.
- **`mode_chg`**: pulses only when the value actually changes. Example: OFF forced while already OFF gives no pulse.
- **Reset behaviour**: the asynchronous reset may assert at any time, including mid-press or mid-debounce. On reset:
  - `cntl` = 0 and `mode_chg` = 0.
  - FSM = IDLE and all counters = 0.
  - Debounced key levels = 1 (released).
- **Keys held through reset release**: a key held low when reset deasserts is seen as a press after normal debounce.
- **Debounce**: 2-flop synchroniser, then a counter. The debounced level flips after `DEB_CYCLES` consecutive synchronised samples that differ from it. Any matching sample clears the counter, so bounces shorter than `DEB_CYCLES` are rejected.

## Timing
- **Raw edge to debounced level/pulse**: a raw edge held stable gives the debounced level change, plus a one-cycle press/release pulse, `2 + DEB_CYCLES` cycles later.
- **Pulse to `cntl`**: `cntl` updates on the clock edge after the pulse. End-to-end, a raw edge reaches `cntl` in `3 + DEB_CYCLES` cycles.
- **Long press**: `cntl` goes to OFF exactly `LONG_CYCLES` cycles after the press pulse.
- **`mode_chg`**: coincident with the first cycle of the new `cntl` value.
- **Back-to-back events**: all events are processed at one per cycle; none are dropped.

## Structure
- **Shared package `led_pkg`**: holds the four mode-code constants and the 4-bit mode type. These are shared with the LED controller so both sides use one encoding.
- **Sub-module `key_debounce`**: synchroniser, debounce counter and press/release pulse generation. Parameterised by `DEB_CYCLES` and instantiated once per key.
- **Top level**: the key-next FSM, the saturating hold counter (width `$clog2(LONG_CYCLES+1)`), the mode register and `mode_chg` generation.

## Test plan
All scenarios use `CLK_FREQ=1000`, `DEBOUNCE_MS=5` (`DEB_CYCLES=5`) and `LONG_MS=50` (`LONG_CYCLES=50`).
1. **Reset defaults**: assert `rst_n` low mid-simulation with keys high → `cntl`=0 and `mode_chg`=0 immediately (asynchronously), and they stay so for 20 cycles after release.
2. **Short-press cycling**: four clean 20-cycle presses of `key_next` → `cntl` steps 1, 2, 3, 0. Each step lands 8 cycles after the raw release and comes with exactly one `mode_chg` pulse.
3. **Bounce rejection**: toggle `key_next` low for 3 cycles, high for 2, repeated 10 times, then stay high → `cntl` unchanged and no `mode_chg`.
4. **Long press**: from `cntl`=2, hold `key_next` for 80 cycles → `cntl`=0 exactly 50 cycles after the press pulse. The release causes no change.
5. **Off key with a simultaneous event**: from `cntl`=3, press `key_off` → `cntl`=0 with one pulse. Then align a `key_off` press with a `key_next` short-release pulse in the same cycle → `cntl` stays 0 and no pulse.
6. **Reset mid-press**: assert reset during the HELD state at hold = 30 → state cleared. A key still held after reset release produces a fresh press; releasing it at hold < 50 advances 0→1.
